// File: rtl/fifo_reader.sv
// Read-side burst controller for the sample fifo.
// Issues one read at a time and forwards each word over a valid/ready stream.
module fifo_reader #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_SIZE       = 5,
  parameter int TIMEOUT_CYCLES  = 8,
  localparam int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE),
  localparam int TW              = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  input  logic [FIFO_SIZE_WIDTH:0]  burst_len,
  input  logic                      flush,
  input  logic [FIFO_SIZE_WIDTH:0]  fifo_size,
  output logic                      fifo_rd_req,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
  input  logic                      fifo_rd_data_rdy,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_vld,
  input  logic                      m_rdy,
  output logic                      m_last,
  output logic                      busy,
  output logic [15:0]               words_sent,
  output logic                      event_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    SEND
  } state_t;

  localparam logic [FIFO_SIZE_WIDTH:0] MAX_LEN =
    (FIFO_SIZE_WIDTH + 1)'(FIFO_SIZE);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_t                   state_q;
  state_t                   state_d;
  logic [FIFO_SIZE_WIDTH:0] eff_len;
  logic [FIFO_SIZE_WIDTH:0] remaining;
  logic [TW-1:0]            timer;
  logic                     start;
  logic                     tmo;
  logic                     accept;

  always_comb begin
    eff_len = burst_len;
    if (burst_len == '0)
      eff_len = 1;
    else if (burst_len > MAX_LEN)
      eff_len = MAX_LEN;
  end

  assign start  = enable && !flush &&
                  (fifo_size >= eff_len);
  assign tmo    = (timer == TMO_LAST);
  assign accept = m_vld && m_rdy;

  assign fifo_rd_req = (state_q == REQ);
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start) state_d = REQ;
      REQ:
        state_d = WAIT_DATA;
      WAIT_DATA:
        if (fifo_rd_data_rdy)
          state_d = SEND;
        else if (tmo)
          state_d = IDLE;
      SEND:
        if (accept)
          state_d = (remaining == 1) ? IDLE : REQ;
      default:
        state_d = IDLE;
    endcase
    // flush wins over any handshake in flight
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data        <= '0;
      m_vld         <= 1'b0;
      m_last        <= 1'b0;
      words_sent    <= '0;
      remaining     <= '0;
      timer         <= '0;
      event_timeout <= 1'b0;
    end else begin
      event_timeout <= 1'b0;
      if (flush) begin
        m_vld  <= 1'b0;
        m_last <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE:
            if (start) remaining <= eff_len;
          REQ:
            timer <= '0;
          WAIT_DATA:
            if (fifo_rd_data_rdy) begin
              m_data <= fifo_rd_data;
              m_vld  <= 1'b1;
              m_last <= (remaining == 1);
            end else if (tmo) begin
              event_timeout <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          SEND:
            if (accept) begin
              words_sent <= words_sent + 1'b1;
              remaining  <= remaining - 1'b1;
              m_vld      <= 1'b0;
              m_last     <= 1'b0;
            end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: behavioural fifo plus a scoreboard
// of expected output words filled as the fifo is loaded.
module tb_fifo_reader;

  localparam int DW = 32;

  logic          clk = 0;
  logic          rstn = 0;
  logic          enable = 0;
  logic [3:0]    burst_len = 0;
  logic          flush = 0;
  logic [3:0]    fifo_size = 0;
  logic          fifo_rd_req;
  logic [DW-1:0] fifo_rd_data = 0;
  logic          fifo_rd_data_rdy = 0;
  logic [DW-1:0] m_data;
  logic          m_vld;
  logic          m_rdy = 1;
  logic          m_last;
  logic          busy;
  logic [15:0]   words_sent;
  logic          event_timeout;

  fifo_reader dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .burst_len(burst_len), .flush(flush),
    .fifo_size(fifo_size), .fifo_rd_req(fifo_rd_req),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_data_rdy(fifo_rd_data_rdy),
    .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy),
    .m_last(m_last), .busy(busy),
    .words_sent(words_sent),
    .event_timeout(event_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int req_cnt = 0;
  int to_cnt = 0;
  int overlap = 0;
  int last_req_cyc = 0;
  int last_to_cyc = 0;
  bit fifo_respond = 1;

  logic [DW-1:0] fq[$];
  logic [DW:0]   sb[$];

  task automatic chk(string tag,
                     logic [63:0] got,
                     logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic push(logic [DW-1:0] d, bit last);
    fq.push_back(d);
    sb.push_back({last, d});
    fifo_size = 4'(fq.size());
  endtask

  task automatic clear_all();
    fq.delete();
    sb.delete();
    fifo_size = 0;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    tick();
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(busy), 0);
  endtask

  task automatic wait_vld(string tag);
    int n = 0;
    while (!m_vld && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 64'(m_vld), 1);
  endtask

  task automatic wait_sent(string tag, int target);
    int n = 0;
    while (words_sent != 16'(target) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(words_sent), 64'(target));
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fifo_rd_req && fifo_respond && rstn) begin
      @(posedge clk);
      #1;
      fifo_rd_data = (fq.size() > 0) ? fq.pop_front() : '0;
      fifo_size = 4'(fq.size());
      fifo_rd_data_rdy = 1;
      @(posedge clk);
      #1;
      fifo_rd_data_rdy = 0;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (fifo_rd_req) begin
        req_cnt++;
        last_req_cyc = cyc;
        if (m_vld) overlap++;
      end
      if (event_timeout) begin
        to_cnt++;
        last_to_cyc = cyc;
      end
      if (m_vld && m_rdy && !flush) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 64'(m_data), 0);
        end else begin
          logic [DW:0] e;
          e = sb.pop_front();
          chk("m_data", 64'(m_data), 64'(e[DW-1:0]));
          chk("m_last", 64'(m_last), 64'(e[DW]));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] hd;
    logic          hl;
    int r0, p;

    #12;
    chk("rst_vld", 64'(m_vld), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_sent", 64'(words_sent), 0);
    chk("rst_req", 64'(fifo_rd_req), 0);
    chk("rst_data", 64'(m_data), 0);
    @(posedge clk);
    #1 rstn = 1;
    tick();

    // basic two-word burst
    burst_len = 2;
    push(32'h1, 0);
    push(32'h2, 1);
    enable = 1;
    wait_idle("b1_idle");
    enable = 0;
    chk("b1_sent", 64'(words_sent), 2);
    chk("b1_reqs", 64'(req_cnt), 2);
    chk("b1_sb", 64'(sb.size()), 0);

    // occupancy threshold
    burst_len = 3;
    push(32'hA0, 0);
    enable = 1;
    r0 = req_cnt;
    tick(6);
    chk("thr_noreq", 64'(req_cnt), 64'(r0));
    chk("thr_busy", 64'(busy), 0);
    push(32'hA1, 0);
    push(32'hA2, 1);
    p = cyc;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("thr_start", 64'(last_req_cyc - p), 1);
    wait_idle("thr_idle");
    enable = 0;
    chk("thr_sent", 64'(words_sent), 5);

    // backpressure on first word
    burst_len = 2;
    push(32'hBEEF0001, 0);
    push(32'hBEEF0002, 1);
    m_rdy = 0;
    enable = 1;
    tick();
    enable = 0;
    wait_vld("bp_vld");
    hd = m_data;
    hl = m_last;
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 64'({m_vld, m_last, m_data}),
          64'({1'b1, hl, hd}));
    end
    chk("bp_noreq", 64'(req_cnt), 64'(r0));
    @(posedge clk);
    #1 m_rdy = 1;
    wait_idle("bp_idle");
    chk("bp_sent", 64'(words_sent), 7);

    // flush while word 2 is held
    burst_len = 4;
    for (int i = 0; i < 4; i++)
      push(32'hC0 + 32'(i), i == 3);
    enable = 1;
    tick();
    enable = 0;
    wait_sent("fl_w1", 8);
    m_rdy = 0;
    wait_vld("fl_vld");
    flush = 1;
    clear_all();
    tick();
    flush = 0;
    chk("fl_vld0", 64'(m_vld), 0);
    chk("fl_busy", 64'(busy), 0);
    chk("fl_sent", 64'(words_sent), 8);

    // flush coincident with handshake
    for (int i = 0; i < 4; i++)
      push(32'hD0 + 32'(i), i == 3);
    enable = 1;
    tick();
    enable = 0;
    wait_vld("flh_vld");
    m_rdy = 1;
    flush = 1;
    clear_all();
    tick();
    flush = 0;
    chk("flh_sent", 64'(words_sent), 8);
    chk("flh_vld0", 64'(m_vld), 0);
    tick(2);

    // fifo never answers
    fifo_respond = 0;
    burst_len = 1;
    push(32'hE0, 1);
    r0 = req_cnt;
    enable = 1;
    tick();
    enable = 0;
    tick(20);
    chk("to_cnt", 64'(to_cnt), 1);
    chk("to_lat", 64'(last_to_cyc - last_req_cyc), 9);
    chk("to_reqs", 64'(req_cnt - r0), 1);
    chk("to_busy", 64'(busy), 0);
    chk("to_vld", 64'(m_vld), 0);
    clear_all();
    fifo_respond = 1;

    // zero length means one word per burst
    burst_len = 0;
    push(32'hF1, 1);
    push(32'hF2, 1);
    enable = 1;
    wait_sent("z_sent", 10);
    enable = 0;
    wait_idle("z_idle");

    // oversize length clamps to fifo depth
    burst_len = 7;
    for (int i = 0; i < 5; i++)
      push(32'h70 + 32'(i), i == 4);
    enable = 1;
    tick();
    enable = 0;
    wait_idle("cl_idle");
    chk("cl_sent", 64'(words_sent), 15);
    chk("cl_sb", 64'(sb.size()), 0);
    chk("ovl", 64'(overlap), 0);

    // asynchronous reset while holding a word
    burst_len = 1;
    push(32'h5A5A5A5A, 1);
    m_rdy = 0;
    enable = 1;
    tick();
    enable = 0;
    wait_vld("ar_vld");
    @(negedge clk);
    #2 rstn = 0;
    #1;
    chk("ar_vld0", 64'(m_vld), 0);
    chk("ar_out", 64'({m_last, busy, m_data}), 0);
    chk("ar_sent", 64'(words_sent), 0);
    clear_all();
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
